// File: rtl/debug_controller_if.sv
// Debug port bundle: host byte stream (rx/tx valid/ready) plus the core-side debug strobes.
// slave = controller view, master = host transport and processor view.
interface debug_controller_if;
    logic [7:0]  iRx_data;
    logic        iRx_valid;
    logic        oRx_ready;
    logic [7:0]  oTx_data;
    logic        oTx_valid;
    logic        iTx_ready;
    logic        oDbg_halt;
    logic        oDbg_exec;
    logic [31:0] oDbg_ins;
    logic        oDbg_reqInit;
    logic        oDbg_regWrite;
    logic [4:0]  oRd_addr;
    logic [31:0] oRd_value;
    logic [4:0]  oRs_addr;
    logic [31:0] iRs_value;

    modport slave (
        input  iRx_data, iRx_valid, iTx_ready, iRs_value,
        output oRx_ready, oTx_data, oTx_valid, oDbg_halt, oDbg_exec, oDbg_ins,
               oDbg_reqInit, oDbg_regWrite, oRd_addr, oRd_value, oRs_addr
    );

    modport master (
        output iRx_data, iRx_valid, iTx_ready, iRs_value,
        input  oRx_ready, oTx_data, oTx_valid, oDbg_halt, oDbg_exec, oDbg_ins,
               oDbg_reqInit, oDbg_regWrite, oRd_addr, oRd_value, oRs_addr
    );
endinterface

// File: rtl/debug_controller.sv
// Host-side debug controller: decodes byte-stream command frames into halt, instruction
// injection, register access and init requests. Define DBG_TIMEOUT_EN for an arg timeout.
module debug_controller #(
    parameter int unsigned HALT_SETTLE    = 8,
    parameter int unsigned EXEC_WAIT      = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic               iClk,
    input logic               nRst,
    debug_controller_if.slave dbg
);
    localparam logic [7:0] OpHalt   = 8'h01;
    localparam logic [7:0] OpResume = 8'h02;
    localparam logic [7:0] OpRdReg  = 8'h03;
    localparam logic [7:0] OpWrReg  = 8'h04;
    localparam logic [7:0] OpExec   = 8'h05;
    localparam logic [7:0] OpInit   = 8'h06;
    localparam logic [7:0] Ack      = 8'hA5;
    localparam logic [7:0] Nak      = 8'h5A;
    localparam int unsigned WaitMax = (HALT_SETTLE > EXEC_WAIT) ? HALT_SETTLE : EXEC_WAIT;
    localparam int unsigned WaitW   = (WaitMax > 1) ? $clog2(WaitMax) : 1;

    typedef enum logic [2:0] {StIdle, StGetArg, StExecute, StWait, StResp} state_e;

    function automatic logic [2:0] arg_count(input logic [7:0] op);
        case (op)
            OpRdReg: arg_count = 3'd1;
            OpWrReg: arg_count = 3'd5;
            OpExec:  arg_count = 3'd4;
            default: arg_count = 3'd0;
        endcase
    endfunction

    // Async assert, synchronous release of the internal reset.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) rst_sync_q <= 2'b00;
        else       rst_sync_q <= rst_sync_d;
    end
    assign rst_n = rst_sync_q[1];

    state_e             state_q, state_d;
    logic [7:0]         op_q, op_d;
    logic [2:0]         arg_idx_q, arg_idx_d;
    logic [39:0]        args_q, args_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [39:0]        tx_buf_q, tx_buf_d;
    logic [2:0]         tx_cnt_q, tx_cnt_d;
    logic               halt_q, halt_d;
    logic               exec_q, exec_d;
    logic [31:0]        ins_q, ins_d;
    logic               init_q, init_d;
    logic               wr_q, wr_d;
    logic [4:0]         rd_addr_q, rd_addr_d;
    logic [31:0]        rd_value_q, rd_value_d;
    logic [4:0]         rs_addr_q, rs_addr_d;

    logic rx_ready, rx_fire, tx_fire, last_arg, arg_timeout;

    assign rx_ready = rst_n && (state_q == StIdle || state_q == StGetArg);
    assign rx_fire  = rx_ready && dbg.iRx_valid;
    assign tx_fire  = (state_q == StResp) && dbg.iTx_ready;
    assign last_arg = (arg_idx_q == arg_count(op_q) - 3'd1);

`ifdef DBG_TIMEOUT_EN
    localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q + ToW'(1);
        if (state_q != StGetArg || rx_fire) to_cnt_d = '0;
    end

    always_ff @(posedge iClk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end

    assign arg_timeout = (state_q == StGetArg) && !rx_fire &&
                         (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
`else
    assign arg_timeout = 1'b0;
`endif

    always_ff @(posedge iClk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rx_fire) state_d = (arg_count(dbg.iRx_data) != 3'd0) ? StGetArg : StExecute;
            end
            StGetArg: begin
                if (rx_fire && last_arg) state_d = StExecute;
                else if (arg_timeout)    state_d = StResp;
            end
            StExecute: begin
                if ((op_q == OpHalt && !halt_q) || (op_q == OpExec && halt_q)) state_d = StWait;
                else                                                            state_d = StResp;
            end
            StWait:  if (wait_q == '0) state_d = StResp;
            StResp:  if (tx_fire && tx_cnt_q == 3'd1) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        op_d       = op_q;
        arg_idx_d  = arg_idx_q;
        args_d     = args_q;
        wait_d     = wait_q;
        tx_buf_d   = tx_buf_q;
        tx_cnt_d   = tx_cnt_q;
        halt_d     = halt_q;
        exec_d     = 1'b0;
        ins_d      = ins_q;
        init_d     = 1'b0;
        wr_d       = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_value_d = rd_value_q;
        rs_addr_d  = rs_addr_q;
        unique case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    op_d      = dbg.iRx_data;
                    arg_idx_d = 3'd0;
                end
            end
            StGetArg: begin
                if (rx_fire) begin
                    // Args shift in from the top so the final word lands at [39:8].
                    args_d    = {dbg.iRx_data, args_q[39:8]};
                    arg_idx_d = arg_idx_q + 3'd1;
                    if (op_q == OpRdReg && halt_q) rs_addr_d = dbg.iRx_data[4:0];
                end else if (arg_timeout) begin
                    tx_buf_d = {32'h0, Nak};
                    tx_cnt_d = 3'd1;
                end
            end
            StExecute: begin
                tx_buf_d = {32'h0, Ack};
                tx_cnt_d = 3'd1;
                case (op_q)
                    OpHalt: begin
                        if (!halt_q) begin
                            halt_d = 1'b1;
                            wait_d = WaitW'(HALT_SETTLE - 1);
                        end
                    end
                    OpResume: halt_d = 1'b0;
                    OpRdReg: begin
                        if (halt_q) begin
                            tx_buf_d = {dbg.iRs_value, Ack};
                            tx_cnt_d = 3'd5;
                        end else begin
                            tx_buf_d = {32'h0, Nak};
                        end
                    end
                    OpWrReg: begin
                        if (halt_q) begin
                            wr_d       = 1'b1;
                            rd_addr_d  = args_q[4:0];
                            rd_value_d = args_q[39:8];
                        end else begin
                            tx_buf_d = {32'h0, Nak};
                        end
                    end
                    OpExec: begin
                        if (halt_q) begin
                            exec_d = 1'b1;
                            ins_d  = args_q[39:8];
                            wait_d = WaitW'(EXEC_WAIT - 1);
                        end else begin
                            tx_buf_d = {32'h0, Nak};
                        end
                    end
                    OpInit:  init_d = 1'b1;
                    default: tx_buf_d = {32'h0, Nak};
                endcase
            end
            StWait: if (wait_q != '0) wait_d = wait_q - WaitW'(1);
            StResp: begin
                if (tx_fire) begin
                    tx_buf_d = {8'h00, tx_buf_q[39:8]};
                    tx_cnt_d = tx_cnt_q - 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            arg_idx_q  <= '0;
            args_q     <= '0;
            wait_q     <= '0;
            tx_buf_q   <= '0;
            tx_cnt_q   <= '0;
            halt_q     <= 1'b0;
            exec_q     <= 1'b0;
            ins_q      <= '0;
            init_q     <= 1'b0;
            wr_q       <= 1'b0;
            rd_addr_q  <= '0;
            rd_value_q <= '0;
            rs_addr_q  <= '0;
        end else begin
            op_q       <= op_d;
            arg_idx_q  <= arg_idx_d;
            args_q     <= args_d;
            wait_q     <= wait_d;
            tx_buf_q   <= tx_buf_d;
            tx_cnt_q   <= tx_cnt_d;
            halt_q     <= halt_d;
            exec_q     <= exec_d;
            ins_q      <= ins_d;
            init_q     <= init_d;
            wr_q       <= wr_d;
            rd_addr_q  <= rd_addr_d;
            rd_value_q <= rd_value_d;
            rs_addr_q  <= rs_addr_d;
        end
    end

    always_comb begin
        dbg.oRx_ready     = rx_ready;
        dbg.oTx_valid     = (state_q == StResp);
        dbg.oTx_data      = tx_buf_q[7:0];
        dbg.oDbg_halt     = halt_q;
        dbg.oDbg_exec     = exec_q;
        dbg.oDbg_ins      = ins_q;
        dbg.oDbg_reqInit  = init_q;
        dbg.oDbg_regWrite = wr_q;
        dbg.oRd_addr      = rd_addr_q;
        dbg.oRd_value     = rd_value_q;
        dbg.oRs_addr      = rs_addr_q;
    end
endmodule

// File: tb/tb_debug_controller.sv
// Randomized bench for debug_controller: a frame-level reference model predicts responses,
// strobes and held outputs; a behavioural regfile serves reads.
module tb_debug_controller;
    localparam int unsigned HaltSettle    = 8;
    localparam int unsigned ExecWait      = 6;
    localparam int unsigned TimeoutCycles = 1024;
    localparam logic [7:0]  Ack = 8'hA5;
    localparam logic [7:0]  Nak = 8'h5A;

    logic iClk = 1'b0;
    logic nRst = 1'b0;
    always #5 iClk = ~iClk;

    debug_controller_if dif ();

    debug_controller #(
        .HALT_SETTLE   (HaltSettle),
        .EXEC_WAIT     (ExecWait),
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .iClk(iClk),
        .nRst(nRst),
        .dbg (dif)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural regfile written by the DUT's strobe, x0 reads as zero.
    logic [31:0] hw_regs [32] = '{default: 32'h0};
    always_comb dif.iRs_value = (dif.oRs_addr == 5'd0) ? 32'h0 : hw_regs[dif.oRs_addr];

    int unsigned cyc = 0, n_exec = 0, n_init = 0, n_wr = 0, n_overlap = 0, n_unstable = 0;
    int unsigned acc_cyc = 0, exec_cyc = 0, halt_rise_cyc = 0, tx_rise_cyc = 0;
    logic        prev_halt = 1'b0, prev_txv = 1'b0, tx_pend = 1'b0;
    logic [7:0]  tx_pend_data = 8'h0;
    logic [7:0]  rxq [$];

    always @(posedge iClk) begin
        cyc <= cyc + 1;
        if ({1'b0, dif.oDbg_exec} + {1'b0, dif.oDbg_reqInit} + {1'b0, dif.oDbg_regWrite} > 2'd1)
            n_overlap <= n_overlap + 1;
        if (dif.oDbg_exec) begin
            n_exec   <= n_exec + 1;
            exec_cyc <= cyc;
        end
        if (dif.oDbg_reqInit) n_init <= n_init + 1;
        if (dif.oDbg_regWrite) begin
            n_wr <= n_wr + 1;
            if (dif.oRd_addr != 5'd0) hw_regs[dif.oRd_addr] <= dif.oRd_value;
        end
        if (dif.iRx_valid && dif.oRx_ready) acc_cyc <= cyc;
        if (dif.oDbg_halt && !prev_halt) halt_rise_cyc <= cyc;
        if (dif.oTx_valid && !prev_txv) tx_rise_cyc <= cyc;
        prev_halt <= dif.oDbg_halt;
        prev_txv  <= dif.oTx_valid;
        if (dif.oTx_valid && dif.iTx_ready) rxq.push_back(dif.oTx_data);
        if (nRst && tx_pend && (!dif.oTx_valid || dif.oTx_data !== tx_pend_data))
            n_unstable <= n_unstable + 1;
        tx_pend      <= dif.oTx_valid && !dif.iTx_ready;
        tx_pend_data <= dif.oTx_data;
    end

    int unsigned stall_pct = 0;
    logic        tx_hold   = 1'b0;
    initial begin
        dif.iTx_ready = 1'b0;
        forever begin
            @(negedge iClk);
            dif.iTx_ready = !tx_hold && ($urandom_range(99) >= stall_pct);
        end
    end

    // Reference model state.
    logic        mdl_halt     = 1'b0;
    logic [31:0] mdl_ins      = 32'h0;
    logic [4:0]  mdl_rd_addr  = 5'h0;
    logic [31:0] mdl_rd_value = 32'h0;
    logic [31:0] mdl_regs [32] = '{default: 32'h0};

    function automatic int unsigned nargs(input logic [7:0] op);
        case (op)
            8'h03:   return 1;
            8'h04:   return 5;
            8'h05:   return 4;
            default: return 0;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int unsigned k;
        k = 0;
        dif.iRx_data  = b;
        dif.iRx_valid = 1'b1;
        @(negedge iClk);
        while (!dif.oRx_ready && k < 300) begin
            @(negedge iClk);
            k++;
        end
        if (!dif.oRx_ready) check_eq("rx_accept", dif.oRx_ready, 1);
        @(posedge iClk);
        #1;
        dif.iRx_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    // Sends one frame (args little-endian in a), then checks the reply and side effects.
    task automatic do_frame(input logic [7:0] op, input logic [39:0] a, input int unsigned gaps);
        logic [7:0]  exp_q [$];
        logic [31:0] word;
        logic [4:0]  addr;
        int unsigned e0, i0, w0, base, k, de, di, dw;
        e0 = n_exec; i0 = n_init; w0 = n_wr; base = rxq.size();
        de = 0; di = 0; dw = 0;
        case (op)
            8'h01: begin exp_q.push_back(Ack); mdl_halt = 1'b1; end
            8'h02: begin exp_q.push_back(Ack); mdl_halt = 1'b0; end
            8'h03: begin
                if (mdl_halt) begin
                    addr = a[4:0];
                    word = mdl_regs[addr];
                    exp_q.push_back(Ack);
                    for (int i = 0; i < 4; i++) exp_q.push_back(word[8*i +: 8]);
                end else exp_q.push_back(Nak);
            end
            8'h04: begin
                if (mdl_halt) begin
                    mdl_rd_addr  = a[4:0];
                    mdl_rd_value = a[39:8];
                    if (a[4:0] != 5'd0) mdl_regs[a[4:0]] = a[39:8];
                    dw = 1;
                    exp_q.push_back(Ack);
                end else exp_q.push_back(Nak);
            end
            8'h05: begin
                if (mdl_halt) begin
                    mdl_ins = a[31:0];
                    de = 1;
                    exp_q.push_back(Ack);
                end else exp_q.push_back(Nak);
            end
            8'h06: begin di = 1; exp_q.push_back(Ack); end
            default: exp_q.push_back(Nak);
        endcase
        send_byte(op);
        for (int i = 0; i < int'(nargs(op)); i++) begin
            if (gaps != 0) idle($urandom_range(gaps));
            send_byte(a[8*i +: 8]);
        end
        k = 0;
        while (rxq.size() < base + exp_q.size() && k < 3000) begin
            idle(1);
            k++;
        end
        idle(6);
        check_eq("resp_len", rxq.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < rxq.size(); i++)
            check_eq("resp_byte", rxq[base + i], exp_q[i]);
        check_eq("exec_pulses", n_exec - e0, de);
        check_eq("init_pulses", n_init - i0, di);
        check_eq("wr_pulses", n_wr - w0, dw);
        check_eq("halt_level", dif.oDbg_halt, mdl_halt);
        check_eq("ins_hold", dif.oDbg_ins, mdl_ins);
        check_eq("rd_hold", {dif.oRd_addr, dif.oRd_value}, {mdl_rd_addr, mdl_rd_value});
    endtask

    task automatic check_outputs_zero();
        check_eq("rst_ctl", {dif.oDbg_halt, dif.oDbg_exec, dif.oDbg_reqInit, dif.oDbg_regWrite,
                             dif.oRx_ready, dif.oTx_valid, dif.oTx_data, dif.oRd_addr,
                             dif.oRs_addr}, 64'h0);
        check_eq("rst_data", {dif.oDbg_ins, dif.oRd_value}, 64'h0);
    endtask

    initial begin
        logic [7:0]  op;
        int unsigned w0, hb, k;
        dif.iRx_valid = 1'b0;
        dif.iRx_data  = 8'h0;
        idle(3);
        check_outputs_zero();
        nRst = 1'b1;
        idle(4);
        check_eq("rx_ready_idle", dif.oRx_ready, 1);

        do_frame(8'h02, 40'h0, 0);
        do_frame(8'h05, 40'h00_0000_0013, 0);
        do_frame(8'h04, 40'h12_3456_7805, 0);
        do_frame(8'h03, 40'h05, 0);
        do_frame(8'hFF, 40'h0, 0);
        do_frame(8'h06, 40'h0, 0);

        do_frame(8'h01, 40'h0, 0);
        check_eq("halt_rise_lat", (halt_rise_cyc - acc_cyc) <= 2, 1);
        check_eq("halt_settle", tx_rise_cyc - halt_rise_cyc, HaltSettle);
        do_frame(8'h01, 40'h0, 0);
        check_eq("rehalt_lat", (tx_rise_cyc - acc_cyc) <= 3, 1);
        do_frame(8'h04, 40'h12_3456_7805, 0);
        do_frame(8'h05, 40'h00_0000_0013, 0);
        check_eq("exec_wait", tx_rise_cyc - exec_cyc, ExecWait);

        hb = rxq.size();
        fork
            do_frame(8'h03, 40'h05, 0);
            begin
                k = 0;
                while (rxq.size() < hb + 2 && k < 100) begin
                    idle(1);
                    k++;
                end
                tx_hold = 1'b1;
                idle(3);
                tx_hold = 1'b0;
            end
        join

        stall_pct = 30;
        repeat (200) begin
            case ($urandom_range(11))
                0, 1:    op = 8'h01;
                2:       op = 8'h02;
                3, 4:    op = 8'h03;
                5, 6:    op = 8'h04;
                7, 8:    op = 8'h05;
                9:       op = 8'h06;
                default: op = 8'($urandom_range(255, 7));
            endcase
            do_frame(op, {$urandom, 8'($urandom)}, 2);
        end
        stall_pct = 0;

        if (!mdl_halt) do_frame(8'h01, 40'h0, 0);
        w0 = n_wr;
        send_byte(8'h04);
        send_byte(8'h07);
        send_byte(8'h11);
        nRst = 1'b0;
        #1;
        check_outputs_zero();
        idle(3);
        nRst = 1'b1;
        mdl_halt = 1'b0; mdl_ins = 32'h0; mdl_rd_addr = 5'h0; mdl_rd_value = 32'h0;
        idle(4);
        check_eq("rst_no_wr", n_wr - w0, 0);
        do_frame(8'h06, 40'h0, 0);
        do_frame(8'h01, 40'h0, 0);
        do_frame(8'h04, 40'hCAFE_F00D_1F, 1);
        do_frame(8'h03, 40'hFF, 1);

`ifdef DBG_TIMEOUT_EN
        w0 = n_wr;
        hb = rxq.size();
        send_byte(8'h04);
        send_byte(8'h05);
        send_byte(8'h06);
        k = 0;
        while (rxq.size() < hb + 1 && k < TimeoutCycles + 200) begin
            idle(1);
            k++;
        end
        idle(4);
        check_eq("to_len", rxq.size() - hb, 1);
        if (rxq.size() > hb) check_eq("to_nak", rxq[hb], Nak);
        check_eq("to_no_wr", n_wr - w0, 0);
        do_frame(8'h02, 40'h0, 0);
`endif

        check_eq("strobe_overlap", n_overlap, 0);
        check_eq("tx_stable", n_unstable, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
